// File: rtl/alu_pkg.sv
// Shared types and constants for the Simple RISC Machine ALU.
// Optional N/V flags are enabled by defining ALU_NV_FLAGS_EN.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath registers and the ALU.
// N and V exist only when ALU_NV_FLAGS_EN is defined.
interface alu_if import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    alu_op_e          ALUop;
    logic [WIDTH-1:0] out;
    logic             Z;
`ifdef ALU_NV_FLAGS_EN
    logic             N;
    logic             V;
`endif

`ifdef ALU_NV_FLAGS_EN
    modport master (output Ain, output Bin, output ALUop, input out, input Z, input N, input V);
    modport slave  (input Ain, input Bin, input ALUop, output out, output Z, output N, output V);
`else
    modport master (output Ain, output Bin, output ALUop, input out, input Z);
    modport slave  (input Ain, input Bin, input ALUop, output out, output Z);
`endif

endinterface

// File: rtl/alu_addsub.sv
// Combinational adder shared by add and subtract; subtract is a + ~b + 1.
module alu_addsub import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum_full;

    // Operand inversion, carry-in injection and signed-overflow detect
    always_comb begin
        if (sub) begin
            w_b_eff = ~b;
        end else begin
            w_b_eff = b;
        end
        w_sum_full = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};
        sum        = w_sum_full[WIDTH-1:0];
        carry      = w_sum_full[WIDTH];
        // Same-sign inputs to the adder with a result of the other sign
        overflow   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: add/sub/and/not-B with a zero flag, one-cycle latency.
// Defining ALU_NV_FLAGS_EN adds registered negative and overflow flags.
module alu import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);

    logic [WIDTH-1:0] w_sum;
    logic             w_sub;
    logic             w_carry_unused;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic [WIDTH-1:0] r_out;
`ifdef ALU_NV_FLAGS_EN
    logic             w_ovf;
    alu_flags_t       w_flags;
    alu_flags_t       r_flags;
`else
    logic             w_ovf_unused;
    logic             r_z;
`endif

    assign w_sub = (bus.ALUop == ALU_SUB);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (bus.Ain),
        .b        (bus.Bin),
        .sub      (w_sub),
        .sum      (w_sum),
        .carry    (w_carry_unused),
`ifdef ALU_NV_FLAGS_EN
        .overflow (w_ovf)
`else
        .overflow (w_ovf_unused)
`endif
    );

    // Operation select and zero detect on the value about to be registered
    always_comb begin
        w_result = '0;
        case (bus.ALUop)
            ALU_ADD:  w_result = w_sum;
            ALU_SUB:  w_result = w_sum;
            ALU_AND:  w_result = bus.Ain & bus.Bin;
            ALU_NOTB: w_result = ~bus.Bin;
            default:  w_result = '0;
        endcase
        w_zero = ~|w_result;
    end

`ifdef ALU_NV_FLAGS_EN
    // Status flags; overflow only has meaning for the arithmetic ops
    always_comb begin
        w_flags   = '0;
        w_flags.z = w_zero;
        w_flags.n = w_result[WIDTH-1];
        if ((bus.ALUop == ALU_ADD) || (bus.ALUop == ALU_SUB)) begin
            w_flags.v = w_ovf;
        end else begin
            w_flags.v = 1'b0;
        end
    end

    // Result and flag registers with synchronous reset priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_flags <= '{z: 1'b1, n: 1'b0, v: 1'b0};
        end else begin
            r_out   <= w_result;
            r_flags <= w_flags;
        end
    end

    assign bus.out = r_out;
    assign bus.Z   = r_flags.z;
    assign bus.N   = r_flags.n;
    assign bus.V   = r_flags.v;
`else
    // Result and zero-flag registers with synchronous reset priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
            r_z   <= 1'b1;
        end else begin
            r_out <= w_result;
            r_z   <= w_zero;
        end
    end

    assign bus.out = r_out;
    assign bus.Z   = r_z;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; N/V checks compile in with ALU_NV_FLAGS_EN.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_if #(.WIDTH(16)) u_if ();

    alu #(.WIDTH(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp_out, input logic exp_z,
                         input logic exp_n, input logic exp_v);
        checks++;
        assert (u_if.out === exp_out) else begin
            errors++;
            $error("FAIL %s out: observed %h expected %h", tag, u_if.out, exp_out);
        end
        checks++;
        assert (u_if.Z === exp_z) else begin
            errors++;
            $error("FAIL %s Z: observed %b expected %b", tag, u_if.Z, exp_z);
        end
`ifdef ALU_NV_FLAGS_EN
        checks++;
        assert (u_if.N === exp_n) else begin
            errors++;
            $error("FAIL %s N: observed %b expected %b", tag, u_if.N, exp_n);
        end
        checks++;
        assert (u_if.V === exp_v) else begin
            errors++;
            $error("FAIL %s V: observed %b expected %b", tag, u_if.V, exp_v);
        end
`else
        if (exp_n === 1'bx || exp_v === 1'bx) begin
            checks = checks + 0;
        end
`endif
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input alu_op_e op);
        u_if.Ain   = a;
        u_if.Bin   = b;
        u_if.ALUop = op;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(16'h1234, 16'hFFFF, ALU_ADD);

        // Reset held over two edges with arbitrary operands
        step();
        check("reset_edge1", 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(16'hFFFF, 16'h0001, ALU_NOTB);
        step();
        check("reset_edge2", 16'h0000, 1'b1, 1'b0, 1'b0);

        rst_n = 1'b1;
        drive(16'd3602, 16'd28420, ALU_ADD);
        step();
        check("add_7d16", 16'h7D16, 1'b0, 1'b0, 1'b0);

        drive(16'd4648, 16'd48329, ALU_ADD);
        step();
        check("add_cef1", 16'hCEF1, 1'b0, 1'b1, 1'b0);

        drive(16'h7FFF, 16'h0001, ALU_ADD);
        step();
        check("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);

        // ALUop churn inside one cycle must leave no trace
        u_if.Ain = 16'd1;
        u_if.Bin = 16'd1;
        u_if.ALUop = ALU_ADD;
        #1 u_if.ALUop = ALU_NOTB;
        #1 u_if.ALUop = ALU_AND;
        #1 u_if.ALUop = ALU_ADD;
        step();
        check("add_churn", 16'd2, 1'b0, 1'b0, 1'b0);

        drive(16'd5, 16'd2, ALU_SUB);
        step();
        check("sub_5_2", 16'd3, 1'b0, 1'b0, 1'b0);

        drive(16'd463, 16'd463, ALU_SUB);
        step();
        check("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b0);

        drive(16'd463, 16'd4630, ALU_SUB);
        step();
        check("sub_neg", 16'hEFB9, 1'b0, 1'b1, 1'b0);

        drive(16'd100, 16'd32868, ALU_SUB);
        step();
        check("sub_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);

        drive(16'hAAAA, 16'h5555, ALU_AND);
        step();
        check("and_zero", 16'h0000, 1'b1, 1'b0, 1'b0);

        drive(16'd52084, 16'd13976, ALU_AND);
        step();
        check("and_0210", 16'h0210, 1'b0, 1'b0, 1'b0);

        drive(16'h0000, 16'd3792, ALU_NOTB);
        step();
        check("notb_f12f", 16'hF12F, 1'b0, 1'b1, 1'b0);

        drive(16'h1357, 16'hFFFF, ALU_NOTB);
        step();
        check("notb_zero", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Reset arriving right after an add discards the next result
        drive(16'd10, 16'd20, ALU_ADD);
        step();
        check("pre_rst_add", 16'd30, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(16'd5, 16'd5, ALU_ADD);
        step();
        check("mid_reset", 16'h0000, 1'b1, 1'b0, 1'b0);

        rst_n = 1'b1;
        drive(16'd9, 16'd4, ALU_SUB);
        step();
        check("post_rst_sub", 16'd5, 1'b0, 1'b0, 1'b0);
        drive(16'hF0F0, 16'hFF00, ALU_AND);
        step();
        check("post_rst_and", 16'hF000, 1'b0, 1'b1, 1'b0);
        drive(16'hABCD, 16'h0000, ALU_NOTB);
        step();
        check("post_rst_notb", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        drive(16'hFFFF, 16'h0001, ALU_ADD);
        step();
        check("post_rst_wrap", 16'h0000, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Registered 16-bit arithmetic/logic unit for the Simple RISC Machine datapath. It sits between the A/B operand registers and the C/status registers. Each clock it performs one of four operations (add, subtract, bitwise AND, bitwise NOT of B) on the two operands and registers the result together with a zero flag.

## Interface
- `WIDTH`, default 16: operand and result width. Every requirement below assumes 16; the RTL must remain correct for any WIDTH ≥ 2.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `Ain` input WIDTH: operand A.
- `Bin` input WIDTH: operand B.
- `ALUop` input 2: operation select.
- `out` output WIDTH: registered result.
- `Z` output 1: registered zero flag; 1 exactly when `out` is all zeros.
- `N` output 1: registered negative flag. Present only with `ALU_NV_FLAGS_EN`.
- `V` output 1: registered signed-overflow flag. Present only with `ALU_NV_FLAGS_EN`.

## Operation
- ALUop encodings:
  - 00: `Ain + Bin`
  - 01: `Ain - Bin`
  - 10: `Ain & Bin`
  - 11: `~Bin` (`Ain` is ignored)
- Add and subtract are modulo 2^WIDTH; carry out is discarded.
- Subtract is computed as `Ain + ~Bin + 1` on one shared adder; it is two's complement, so 463 - 4630 gives 0xEFB9.
- `Z` is computed from the next result value, so it always matches the registered `out`.
- There is no result history. The output depends only on the operands and ALUop sampled at the most recent edge. Changing ALUop several times before an edge has no residual effect.
- No illegal opcodes: all four encodings are defined.
- Operands are treated as unsigned bit vectors for `out` and `Z`. Signed interpretation is used only for `N` and `V`.

## Timing
- Latency is one cycle. `Ain`, `Bin` and `ALUop` are sampled at rising edge k; `out` and `Z` (plus `N`/`V`) reflect them immediately after edge k and hold until edge k+1.
- A new operation is accepted every cycle. There is no handshake and no stall.
- Reset: if `rst_n` is 0 at a rising edge, then `out` = 0, `Z` = 1, `N` = 0, `V` = 0, regardless of the inputs. Reset has priority over computation.
- Deasserting reset lets the first computed result appear after the next edge at which `rst_n` = 1.
- Asserting reset mid-stream discards the in-flight result. The post-reset values appear after that edge.
- Before the first edge outputs are X; the bench must apply reset for at least one edge.

## Configuration
- Macro: `ALU_NV_FLAGS_EN`.
- When defined:
  - Ports `N` and `V` exist and are registered alongside `Z`.
  - `N` = MSB of the result.
  - For add, `V` = 1 when both operands have the same sign and the result sign differs.
  - For subtract, `V` = 1 when the operands have different signs and the result sign differs from `Ain`.
  - For AND and NOT, `V` = 0.
- When undefined: `N` and `V` ports and their logic are absent. `out` and `Z` behaviour is identical in both builds.

## Structure
- Package `alu_pkg` holds:
  - the `ALU_WIDTH = 16` constant;
  - the 2-bit ALUop enum typedef `ALU_ADD`=00, `ALU_SUB`=01, `ALU_AND`=10, `ALU_NOTB`=11;
  - a status-flag struct typedef (Z, N, V).
- Sub-module `alu_addsub`, combinational, shared by add and subtract:
  - inputs: `a`, `b`, `sub`;
  - outputs: `sum`, `carry`, `overflow`;
  - `b` is inverted and carry-in forced to 1 when `sub` is set.
- Top level contains the operation mux, zero detect and output registers.

## Test plan
- Reset held for 2 edges with arbitrary inputs: `out` = 0x0000, `Z` = 1 (and `N` = `V` = 0 with the macro).
- Add: 3602 + 28420 gives 32022 (0x7D16), `Z` = 0. Add 4648 + 48329 gives 52977 (0xCEF1), `Z` = 0. Add 1 + 1 after cycling ALUop 00→11→10→00 gives 2.
- Subtract: 5 - 2 gives 3, `Z` = 0. 463 - 463 gives 0, `Z` = 1. 463 - 4630 gives 0xEFB9, `Z` = 0. 100 - 32868 gives 0x8000, `Z` = 0, and with the macro `N` = 1 and `V` = 1.
- AND: 0xAAAA & 0x5555 gives 0, `Z` = 1. 52084 & 13976 gives 528 (0x0210), `Z` = 0.
- NOT: `Bin` = 3792 gives 61743 (0xF12F), `Z` = 0. `Bin` = 0xFFFF gives 0, `Z` = 1, independent of `Ain`.
- Reset mid-stream: issue an ADD, assert `rst_n` = 0 at the next edge. `out` = 0, `Z` = 1 after that edge, and back-to-back operations afterwards each have one-cycle latency.
